// File: rtl/hex_update_queue.sv
// Hex-digit update queue feeding the 7-segment latch stage.
// Update requests are buffered in a small FIFO and decoded to active-low
// segment patterns. Each pattern is presented with a one-cycle io_flag strobe,
// and consecutive strobes are kept at least HOLD_CYCLES apart.
module hex_update_queue #(
   parameter int DEPTH       = 4,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [3:0]               wr_data,
   input  logic                     wr_blank,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [6:0]               seg_out,
   output logic                     io_flag
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic {
      READY = 1'b0,
      HOLD  = 1'b1
   } paceState_e;

   logic [4:0]    mem_q [DEPTH];
   logic [AW-1:0] wrPtr_q, wrPtr_d;
   logic [AW-1:0] rdPtr_q, rdPtr_d;
   logic [AW:0]   count_q, count_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [6:0]    seg_q, seg_d;
   logic          ioFlag_q, ioFlag_d;
   logic          overflow_q, overflow_d;
   paceState_e    paceState;
   logic          pushOk;
   logic          popOk;
   logic [4:0]    headEntry;
   logic [6:0]    headSeg;

   assign full     = (count_q == (AW+1)'(DEPTH));
   assign count    = count_q;
   assign overflow = overflow_q;
   assign seg_out  = seg_q;
   assign io_flag  = ioFlag_q;

   // Pacing state is simply whether the hold counter has run out.
   always_comb begin
      paceState = (cnt_q == '0) ? READY : HOLD;
   end

   // Push uses the occupancy before any same-edge pop, and pop only sees
   // entries already stored, so an entry can never bypass through in one edge.
   always_comb begin
      pushOk = wr_en && !full;
      popOk  = (paceState == READY) && (count_q != '0);
   end

   // Decode the head entry into an active-low gfedcba pattern.
   always_comb begin
      headEntry = mem_q[rdPtr_q];
      headSeg   = 7'b1111111;
      if (!headEntry[4]) begin
         case (headEntry[3:0])
            4'h0: headSeg = 7'b1000000;
            4'h1: headSeg = 7'b1111001;
            4'h2: headSeg = 7'b0100100;
            4'h3: headSeg = 7'b0110000;
            4'h4: headSeg = 7'b0011001;
            4'h5: headSeg = 7'b0010010;
            4'h6: headSeg = 7'b0000010;
            4'h7: headSeg = 7'b1111000;
            4'h8: headSeg = 7'b0000000;
            4'h9: headSeg = 7'b0010000;
            4'hA: headSeg = 7'b0001000;
            4'hB: headSeg = 7'b0000011;
            4'hC: headSeg = 7'b1000110;
            4'hD: headSeg = 7'b0100001;
            4'hE: headSeg = 7'b0000110;
            default: headSeg = 7'b0001110;
         endcase
      end
   end

   // Next-state logic for pointers, occupancy, pacing counter and outputs.
   always_comb begin
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      count_d    = count_q;
      cnt_d      = cnt_q;
      seg_d      = seg_q;
      ioFlag_d   = 1'b0;
      overflow_d = overflow_q;

      if (pushOk) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (wr_en && full) begin
         overflow_d = 1'b1;
      end

      if (popOk) begin
         rdPtr_d  = rdPtr_q + 1'b1;
         seg_d    = headSeg;
         ioFlag_d = 1'b1;
         cnt_d    = CW'(HOLD_CYCLES - 1);
      end else if (paceState == HOLD) begin
         cnt_d = cnt_q - 1'b1;
      end

      case ({pushOk, popOk})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         cnt_q      <= '0;
         seg_q      <= 7'b1111111;
         ioFlag_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         cnt_q      <= cnt_d;
         seg_q      <= seg_d;
         ioFlag_q   <= ioFlag_d;
         overflow_q <= overflow_d;
      end
   end

   // FIFO storage; entries are only read once the occupancy says they exist.
   always_ff @(posedge clk) begin
      if (!reset && pushOk) begin
         mem_q[wrPtr_q] <= {wr_blank, wr_data};
      end
   end

endmodule

// File: tb/tb_hex_update_queue.sv
// Testbench for hex_update_queue: three instances with different hold times
// share one stimulus stream and are compared against a list-based model.
module tb_hex_update_queue;

   localparam int NINST = 3;
   localparam int DEPTH = 4;
   localparam int HOLDS [NINST] = '{4, 1, 8};

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wrEn = 1'b0;
   logic [3:0] wrData = 4'h0;
   logic       wrBlank = 1'b0;

   logic       fullObs  [NINST];
   logic [2:0] countObs [NINST];
   logic       ovfObs   [NINST];
   logic [6:0] segObs   [NINST];
   logic       flagObs  [NINST];

   // Reference model: an ordered list of pending entries per instance,
   // plus the number of cycles still to wait before the next strobe.
   logic [4:0] mBuf [NINST][DEPTH];
   int         mLen  [NINST];
   int         mWait [NINST];
   logic [6:0] expSeg  [NINST];
   logic       expFlag [NINST];
   logic       expOvf  [NINST];

   int testCount = 0;
   int failCount = 0;

   // 10 ns clock period.
   always #5 clk = ~clk;

   for (genvar g = 0; g < NINST; g++) begin : gDut
      hex_update_queue #(
         .DEPTH(DEPTH),
         .HOLD_CYCLES(HOLDS[g])
      ) u_dut (
         .clk(clk),
         .reset(reset),
         .wr_en(wrEn),
         .wr_data(wrData),
         .wr_blank(wrBlank),
         .full(fullObs[g]),
         .count(countObs[g]),
         .overflow(ovfObs[g]),
         .seg_out(segObs[g]),
         .io_flag(flagObs[g])
      );
   end

   // Advance the model by one clock edge using the inputs seen at that edge.
   task automatic modelEdge();
      for (int i = 0; i < NINST; i++) begin
         if (reset) begin
            mLen[i]    = 0;
            mWait[i]   = 0;
            expSeg[i]  = 7'b1111111;
            expFlag[i] = 1'b0;
            expOvf[i]  = 1'b0;
         end else begin
            bit accept;
            accept = wrEn && (mLen[i] < DEPTH);
            if (wrEn && !accept) expOvf[i] = 1'b1;
            if (mWait[i] == 0 && mLen[i] > 0) begin
               expSeg[i]  = mBuf[i][0][4] ? 7'b1111111 : SEG_TABLE[mBuf[i][0][3:0]];
               expFlag[i] = 1'b1;
               for (int k = 0; k < DEPTH - 1; k++) mBuf[i][k] = mBuf[i][k+1];
               mLen[i]  = mLen[i] - 1;
               mWait[i] = HOLDS[i] - 1;
            end else begin
               expFlag[i] = 1'b0;
               if (mWait[i] > 0) mWait[i] = mWait[i] - 1;
            end
            if (accept) begin
               mBuf[i][mLen[i]] = {wrBlank, wrData};
               mLen[i] = mLen[i] + 1;
            end
         end
      end
   endtask

   task automatic checkOutput(input string tag, input int inst,
                              input logic [7:0] observed, input logic [7:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s inst%0d observed=%b expected=%b t=%0t",
                tag, inst, observed, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, clock it, then compare all instances.
   task automatic applyStimulus(input logic en, input logic [3:0] data,
                                input logic blank, input logic rst);
      wrEn    = en;
      wrData  = data;
      wrBlank = blank;
      reset   = rst;
      @(posedge clk);
      modelEdge();
      #1;
      for (int i = 0; i < NINST; i++) begin
         checkOutput("seg_out",  i, {1'b0, segObs[i]},          {1'b0, expSeg[i]});
         checkOutput("io_flag",  i, {7'b0, flagObs[i]},         {7'b0, expFlag[i]});
         checkOutput("count",    i, {5'b0, countObs[i]},        8'(mLen[i]));
         checkOutput("full",     i, {7'b0, fullObs[i]},         {7'b0, (mLen[i] == DEPTH)});
         checkOutput("overflow", i, {7'b0, ovfObs[i]},          {7'b0, expOvf[i]});
      end
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset, then sit idle.
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
      idle(10);

      // Single digit.
      applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
      idle(12);

      // Four updates on consecutive edges, the last one blank.
      applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'hA, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'h5, 1'b1, 1'b0);
      idle(20);

      // Six back-to-back pushes to overrun the slower instances.
      for (int d = 0; d < 6; d++) applyStimulus(1'b1, 4'(d + 7), 1'b0, 1'b0);
      idle(45);

      // Fresh reset, then a continuous feed that wraps both pointers.
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
      for (int d = 0; d < 18; d++) applyStimulus(1'b1, 4'(d), 1'b0, 1'b0);
      idle(45);

      // Reset with entries queued and the hold counter mid-count.
      applyStimulus(1'b1, 4'hC, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'hD, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'hE, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
      idle(10);
      applyStimulus(1'b1, 4'h8, 1'b0, 1'b0);
      idle(10);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 400; c++) begin
         applyStimulus($urandom_range(0, 9) < 4,
                       4'($urandom_range(0, 15)),
                       $urandom_range(0, 7) == 0,
                       $urandom_range(0, 59) == 0);
      end
      idle(40);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
